// File: rtl/bsg_manycore_host_arb_pkg.sv
// Shared types and helpers for the host-link arbiter: FSM state encoding
// and the width of the requester id stamped into packet tag fields.
package bsg_manycore_host_arb_pkg;

  typedef enum logic [0:0] {e_idle, e_hold} arb_state_e;

  // A single requester still needs one stamp bit so the tag slice is never empty.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, with wrap.
module bsg_arb_round_robin #(
  parameter int width_p    = 3,
  parameter int id_width_p = 2
) (
  input  logic [width_p-1:0]    reqs_i,
  input  logic [id_width_p-1:0] ptr_i,
  output logic [id_width_p-1:0] grant_id_o,
  output logic                  v_o
);

  int                    idx;
  logic [id_width_p-1:0] idx_w;

  // Scan from farthest to nearest so the nearest requester overwrites last.
  always_comb begin
    v_o        = 1'b0;
    grant_id_o = '0;
    idx        = 0;
    idx_w      = '0;
    for (int k = width_p - 1; k >= 0; k--) begin
      idx   = (int'(ptr_i) + k) % width_p;
      idx_w = id_width_p'(idx);
      if (reqs_i[idx_w]) begin
        v_o        = 1'b1;
        grant_id_o = idx_w;
      end
    end
  end

endmodule

// File: rtl/bsg_manycore_host_arb_counter.sv
// Saturating up/down counter; simultaneous up and down cancel.
// err_o flags an increment at max or a decrement at zero.
module bsg_manycore_host_arb_counter #(
  parameter int max_val_p  = 16,
  parameter int init_val_p = 0,
  parameter int width_p    = $clog2(max_val_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               up_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_o,
  output logic               err_o
);

  logic inc, dec, at_max, at_zero;

  assign inc     = up_i & ~down_i;
  assign dec     = down_i & ~up_i;
  assign at_max  = (count_o == width_p'(max_val_p));
  assign at_zero = (count_o == '0);
  assign err_o   = (inc & at_max) | (dec & at_zero);

  always_ff @(posedge clk_i) begin
    if (reset_i)                count_o <= width_p'(init_val_p);
    else if (inc && !at_max)    count_o <= count_o + 1'b1;
    else if (dec && !at_zero)   count_o <= count_o - 1'b1;
  end

endmodule

// File: rtl/bsg_manycore_host_link_arbiter.sv
// Shares the host-facing manycore IO endpoint among num_req_p requesters:
// round-robin issue with credit flow control, id-stamped tags, response demux.
module bsg_manycore_host_link_arbiter
  import bsg_manycore_host_arb_pkg::*;
#(
  parameter int num_req_p         = 3,
  parameter int pkt_width_p       = 128,
  parameter int rsp_width_p       = 64,
  parameter int req_tag_lsb_p     = 8,
  parameter int rsp_tag_lsb_p     = 0,
  parameter int max_out_credits_p = 32,
  parameter int max_req_out_p     = 16
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [num_req_p-1:0]                  req_v_i,
  input  logic [num_req_p-1:0][pkt_width_p-1:0] req_pkt_i,
  input  logic [num_req_p-1:0]                  req_expect_rsp_i,
  output logic [num_req_p-1:0]                  req_ready_o,
  output logic                                  pkt_v_o,
  output logic [pkt_width_p-1:0]                pkt_o,
  input  logic                                  pkt_ready_i,
  input  logic                                  credit_return_i,
  input  logic                                  rsp_v_i,
  input  logic [rsp_width_p-1:0]                rsp_pkt_i,
  output logic                                  rsp_yumi_o,
  output logic [num_req_p-1:0]                  rsp_v_o,
  output logic [rsp_width_p-1:0]                rsp_pkt_o,
  input  logic [num_req_p-1:0]                  rsp_yumi_i,
  output logic                                  busy_o,
  output logic                                  err_o
);

  localparam int id_width_lp   = id_width(num_req_p);
  localparam int cnt_width_lp  = $clog2(max_req_out_p + 1);
  localparam int cred_width_lp = $clog2(max_out_credits_p + 1);

  arb_state_e                              state_r, state_n;
  logic [id_width_lp-1:0]                  ptr_r, hold_id_r, arb_id, grant_id;
  logic [id_width_lp-1:0]                  rsp_id, rsp_idx;
  logic                                    arb_v, issue, send, cred_err, err_r;
  logic                                    rsp_id_ok, rsp_good;
  logic [num_req_p-1:0]                    eligible, cnt_up, cnt_down, cnt_err;
  logic [cred_width_lp-1:0]                credits;
  logic [num_req_p-1:0][cnt_width_lp-1:0]  out_cnt;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < num_req_p; i++)
      eligible[i] = req_v_i[i] & (credits != '0)
                  & (~req_expect_rsp_i[i] | (out_cnt[i] < cnt_width_lp'(max_req_out_p)));
  end

  bsg_arb_round_robin #(.width_p(num_req_p), .id_width_p(id_width_lp)) rr (
    .reqs_i(eligible), .ptr_i(ptr_r), .grant_id_o(arb_id), .v_o(arb_v)
  );

  // State register; a held grant is latched only on the IDLE->HOLD transition.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r   <= e_idle;
      ptr_r     <= '0;
      hold_id_r <= '0;
    end else begin
      state_r <= state_n;
      if (state_r == e_idle && state_n == e_hold) hold_id_r <= arb_id;
      if (send) ptr_r <= (grant_id == id_width_lp'(num_req_p - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_idle:  if (arb_v && !pkt_ready_i) state_n = e_hold;
      e_hold:  if (pkt_ready_i)           state_n = e_idle;
      default: state_n = e_idle;
    endcase
  end

  // Issue path is combinational from request to endpoint in IDLE.
  always_comb begin
    grant_id    = (state_r == e_hold) ? hold_id_r : arb_id;
    issue       = ~reset_i & ((state_r == e_hold) | arb_v);
    send        = issue & pkt_ready_i;
    pkt_v_o     = issue;
    pkt_o       = req_pkt_i[grant_id];
    pkt_o[req_tag_lsb_p +: id_width_lp] = grant_id;
    req_ready_o = '0;
    req_ready_o[grant_id] = send;
  end

  bsg_manycore_host_arb_counter #(
    .max_val_p(max_out_credits_p), .init_val_p(max_out_credits_p), .width_p(cred_width_lp)
  ) credit_cnt (
    .clk_i, .reset_i, .up_i(credit_return_i), .down_i(send),
    .count_o(credits), .err_o(cred_err)
  );

  for (genvar i = 0; i < num_req_p; i++) begin : g_out
    assign cnt_up[i]   = send & (grant_id == id_width_lp'(i)) & req_expect_rsp_i[i];
    assign cnt_down[i] = rsp_v_o[i] & rsp_yumi_i[i];
    bsg_manycore_host_arb_counter #(
      .max_val_p(max_req_out_p), .init_val_p(0), .width_p(cnt_width_lp)
    ) out_cnt_inst (
      .clk_i, .reset_i, .up_i(cnt_up[i]), .down_i(cnt_down[i]),
      .count_o(out_cnt[i]), .err_o(cnt_err[i])
    );
  end

  // Responses with an unknown id or no matching outstanding request are dropped.
  assign rsp_id = rsp_pkt_i[rsp_tag_lsb_p +: id_width_lp];

  always_comb begin
    rsp_id_ok  = (int'(rsp_id) < num_req_p);
    rsp_idx    = rsp_id_ok ? rsp_id : '0;
    rsp_good   = rsp_id_ok & (out_cnt[rsp_idx] != '0);
    rsp_v_o    = '0;
    rsp_v_o[rsp_idx] = ~reset_i & rsp_v_i & rsp_good;
    rsp_yumi_o = ~reset_i & rsp_v_i & (rsp_good ? rsp_yumi_i[rsp_idx] : 1'b1);
    rsp_pkt_o  = rsp_pkt_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) err_r <= 1'b0;
    else         err_r <= err_r | cred_err | (|cnt_err) | (rsp_v_i & ~rsp_good);
  end

  assign err_o  = err_r;
  assign busy_o = (credits != cred_width_lp'(max_out_credits_p)) | (|out_cnt)
                | (state_r == e_hold);

endmodule

// File: tb/tb_bsg_manycore_host_link_arbiter.sv
// Directed bench for the host-link arbiter: round-robin order, hold, credits,
// per-requester caps, response demux and error handling.
module tb_bsg_manycore_host_link_arbiter;

  localparam int N = 3;

  logic                 clk = 1'b0;
  logic                 reset_i;
  logic [N-1:0]         req_v_i, req_expect_rsp_i, req_ready_o;
  logic [N-1:0][127:0]  req_pkt_i;
  logic                 pkt_v_o, pkt_ready_i, credit_return_i;
  logic [127:0]         pkt_o;
  logic                 rsp_v_i, rsp_yumi_o, busy_o, err_o;
  logic [63:0]          rsp_pkt_i, rsp_pkt_o;
  logic [N-1:0]         rsp_v_o, rsp_yumi_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bsg_manycore_host_link_arbiter dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_v_i(req_v_i), .req_pkt_i(req_pkt_i), .req_expect_rsp_i(req_expect_rsp_i),
    .req_ready_o(req_ready_o), .pkt_v_o(pkt_v_o), .pkt_o(pkt_o), .pkt_ready_i(pkt_ready_i),
    .credit_return_i(credit_return_i), .rsp_v_i(rsp_v_i), .rsp_pkt_i(rsp_pkt_i),
    .rsp_yumi_o(rsp_yumi_o), .rsp_v_o(rsp_v_o), .rsp_pkt_o(rsp_pkt_o),
    .rsp_yumi_i(rsp_yumi_i), .busy_o(busy_o), .err_o(err_o)
  );

  // Original tag bits [9:8] are 2'b11; the arbiter overwrites them with the grant id.
  localparam logic [127:0] P0 = {32'hA000_0000, 80'h0, 16'h03FF};
  localparam logic [127:0] P1 = {32'hB000_0000, 80'h0, 16'h03FF};
  localparam logic [127:0] P2 = {32'hC000_0000, 80'h0, 16'h03FF};
  localparam logic [127:0] E0 = {32'hA000_0000, 80'h0, 16'h00FF};
  localparam logic [127:0] E1 = {32'hB000_0000, 80'h0, 16'h01FF};
  localparam logic [127:0] E2 = {32'hC000_0000, 80'h0, 16'h02FF};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_i = 1'b1; req_v_i = 3'b111; req_expect_rsp_i = '0; pkt_ready_i = 1'b1;
    credit_return_i = 1'b0; rsp_v_i = 1'b1; rsp_pkt_i = '0; rsp_yumi_i = 3'b111;
    req_pkt_i[0] = P0; req_pkt_i[1] = P1; req_pkt_i[2] = P2;

    // Reset: outputs held low even with live requests and responses.
    tick(); tick(); tick(); settle();
    chk("rst_pkt_v", pkt_v_o, 0);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_rsp_v", rsp_v_o, 0);
    chk("rst_rsp_yumi", rsp_yumi_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_busy", busy_o, 0);
    reset_i = 1'b0; req_v_i = '0; rsp_v_i = 1'b0; rsp_yumi_i = '0;
    tick();

    // Round robin, all requesting, endpoint always ready.
    req_v_i = 3'b111;
    for (int k = 0; k < 6; k++) begin
      settle();
      chk($sformatf("rr_ready_%0d", k), req_ready_o, 3'b001 << (k % 3));
      chk($sformatf("rr_pkt_%0d", k), pkt_o, (k % 3 == 0) ? E0 : (k % 3 == 1) ? E1 : E2);
      chk($sformatf("rr_v_%0d", k), pkt_v_o, 1);
      tick();
    end
    req_v_i = '0;
    settle();
    chk("rr_busy", busy_o, 1);
    credit_return_i = 1'b1;
    repeat (6) tick();
    credit_return_i = 1'b0;
    settle();
    chk("rr_idle_busy", busy_o, 0);
    tick();

    // Hold: requester 1 wins, endpoint stalls 4 cycles, requester 2 waits.
    req_v_i = 3'b110; pkt_ready_i = 1'b0;
    settle();
    chk("hold_v0", pkt_v_o, 1);
    chk("hold_pkt0", pkt_o, E1);
    chk("hold_ready0", req_ready_o, 0);
    tick();
    for (int k = 1; k < 4; k++) begin
      settle();
      chk($sformatf("hold_pkt%0d", k), pkt_o, E1);
      chk($sformatf("hold_ready%0d", k), req_ready_o, 0);
      chk($sformatf("hold_busy%0d", k), busy_o, 1);
      tick();
    end
    pkt_ready_i = 1'b1;
    settle();
    chk("hold_release", req_ready_o, 3'b010);
    chk("hold_release_pkt", pkt_o, E1);
    tick();
    settle();
    chk("hold_next", req_ready_o, 3'b100);
    chk("hold_next_pkt", pkt_o, E2);
    tick();
    req_v_i = '0;
    tick();

    // Credits: 30 remain; drain them, then trickle single credits back.
    req_v_i = 3'b001;
    for (int k = 0; k < 30; k++) begin
      settle();
      chk($sformatf("cred_send_%0d", k), req_ready_o, 3'b001);
      tick();
    end
    settle();
    chk("cred_empty_v", pkt_v_o, 0);
    chk("cred_empty_ready", req_ready_o, 0);
    credit_return_i = 1'b1;
    tick();
    credit_return_i = 1'b0;
    settle();
    chk("cred_one_v", pkt_v_o, 1);
    chk("cred_one_ready", req_ready_o, 3'b001);
    tick();
    settle();
    chk("cred_one_spent", pkt_v_o, 0);
    req_v_i = '0; credit_return_i = 1'b1;
    tick();
    req_v_i = 3'b001;
    settle();
    chk("cred_same_cyc", req_ready_o, 3'b001);
    tick();
    credit_return_i = 1'b0;
    settle();
    chk("cred_unchanged", req_ready_o, 3'b001);
    tick();
    settle();
    chk("cred_drained", pkt_v_o, 0);
    req_v_i = '0; credit_return_i = 1'b1;
    repeat (32) tick();
    credit_return_i = 1'b0;
    settle();
    chk("cred_full_busy", busy_o, 0);
    chk("cred_full_err", err_o, 0);
    credit_return_i = 1'b1;
    tick();
    credit_return_i = 1'b0;
    settle();
    chk("cred_over_err", err_o, 1);
    chk("cred_over_busy", busy_o, 0);
    reset_i = 1'b1;
    tick(); tick();
    reset_i = 1'b0;
    settle();
    chk("cred_rst_err", err_o, 0);
    tick();

    // Per-requester cap: requester 0 expects responses, requester 1 does not.
    req_v_i = 3'b011; req_expect_rsp_i = 3'b001; credit_return_i = 1'b1;
    for (int k = 0; k < 32; k++) begin
      settle();
      chk($sformatf("cap_alt_%0d", k), req_ready_o, (k % 2 == 0) ? 3'b001 : 3'b010);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("cap_block_%0d", k), req_ready_o, 3'b010);
      tick();
    end
    settle();
    chk("cap_busy", busy_o, 1);
    rsp_v_i = 1'b1; rsp_pkt_i = 64'hDEAD_BEEF_0000_0100; rsp_yumi_i = 3'b001;
    settle();
    chk("rsp0_v", rsp_v_o, 3'b001);
    chk("rsp0_yumi", rsp_yumi_o, 1);
    chk("rsp0_pkt", rsp_pkt_o, 64'hDEAD_BEEF_0000_0100);
    chk("rsp0_still_blocked", req_ready_o, 3'b010);
    tick();
    rsp_v_i = 1'b0; rsp_yumi_i = '0;
    settle();
    chk("cap_reopen", req_ready_o, 3'b001);
    tick();
    req_v_i = '0; credit_return_i = 1'b0; req_expect_rsp_i = '0;

    // Bad responses: unknown id, then id with nothing outstanding.
    rsp_v_i = 1'b1; rsp_pkt_i = 64'h1234_0000_0000_0003; rsp_yumi_i = '0;
    settle();
    chk("bad_id_yumi", rsp_yumi_o, 1);
    chk("bad_id_v", rsp_v_o, 0);
    chk("bad_id_err_pre", err_o, 0);
    tick();
    rsp_pkt_i = 64'h1234_0000_0000_0002; rsp_yumi_i = 3'b100;
    settle();
    chk("no_out_v", rsp_v_o, 0);
    chk("no_out_yumi", rsp_yumi_o, 1);
    chk("bad_id_err", err_o, 1);
    tick();
    rsp_v_i = 1'b0; rsp_yumi_i = '0;
    settle();
    chk("err_sticky", err_o, 1);
    chk("err_busy_out", busy_o, 1);
    tick();

    // Reset mid-hold drops the grant without emitting.
    reset_i = 1'b1;
    tick(); tick();
    reset_i = 1'b0;
    settle();
    chk("rst2_err", err_o, 0);
    chk("rst2_busy", busy_o, 0);
    req_v_i = 3'b010; pkt_ready_i = 1'b0;
    settle();
    chk("rsth_v", pkt_v_o, 1);
    chk("rsth_pkt", pkt_o, E1);
    tick();
    settle();
    chk("rsth_busy", busy_o, 1);
    reset_i = 1'b1;
    settle();
    chk("rsth_v_in_rst", pkt_v_o, 0);
    chk("rsth_ready_in_rst", req_ready_o, 0);
    tick();
    reset_i = 1'b0; req_v_i = '0;
    settle();
    chk("rsth_after_v", pkt_v_o, 0);
    chk("rsth_after_busy", busy_o, 0);
    tick();
    req_v_i = 3'b100; pkt_ready_i = 1'b1;
    settle();
    chk("post_rst_grant", req_ready_o, 3'b100);
    chk("post_rst_pkt", pkt_o, E2);
    tick();
    req_v_i = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_manycore_host_link_arbiter.md
Name: bsg_manycore_host_link_arbiter

Overview:
Shares the single host-facing manycore IO endpoint (IO router column 0, P port) among num_req_p host-side requesters (host DMA engine, BP MMIO bridge, debug agent). Round-robin arbitration on the request path with global and per-requester credit flow control. Stamps the requester index into the packet tag field and uses the same field to demultiplex returning responses. Sits between the host requesters and the endpoint that drives the IO link.

Parameters:
num_req_p, 3, number of requesters (2..8); id_width_lp = clog2(num_req_p)
pkt_width_p, 128, opaque request packet width
rsp_width_p, 64, opaque response packet width
req_tag_lsb_p, 8, LSB of the id stamp bits inside the request packet
rsp_tag_lsb_p, 0, LSB of the id bits inside the response packet
max_out_credits_p, 32, global outstanding-request credits at the endpoint
max_req_out_p, 16, per-requester cap on outstanding responses

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
req_v_i  in  num_req_p  request valid, per requester
req_pkt_i  in  num_req_p*pkt_width_p  request packets
req_expect_rsp_i  in  num_req_p  request generates a response
req_ready_o  out  num_req_p  request accepted this cycle
pkt_v_o  out  1  packet valid to endpoint
pkt_o  out  pkt_width_p  stamped packet
pkt_ready_i  in  1  endpoint accepts
credit_return_i  in  1  endpoint returns one credit
rsp_v_i  in  1  response valid from endpoint
rsp_pkt_i  in  rsp_width_p  response packet
rsp_yumi_o  out  1  response consumed
rsp_v_o  out  num_req_p  response valid, per requester
rsp_pkt_o  out  rsp_width_p  response data, broadcast
rsp_yumi_i  in  num_req_p  requester consumes response
busy_o  out  1  any credit or response outstanding
err_o  out  1  sticky: bad response id or counter underflow

Behaviour:
- Reset: pkt_v_o=0, req_ready_o=0, rsp_v_o=0, rsp_yumi_o=0, err_o=0, busy_o=0; credits=max_out_credits_p; outstanding counters=0; RR pointer=0. Reset mid-transfer drops a held grant without emitting.
- Eligible(i) = req_v_i[i] & credits>0 & (!req_expect_rsp_i[i] | out_cnt[i]<max_req_out_p).
- FSM IDLE/HOLD. IDLE: pick first eligible index at or after the RR pointer (wrap). Issue combinationally: pkt_v_o=1, pkt_o=req_pkt_i[g] with bits [req_tag_lsb_p +: id_width_lp] replaced by g. If pkt_ready_i: req_ready_o[g]=1, pointer<=g+1 mod num_req_p, stay IDLE. Else register g -> HOLD.
- HOLD: grant fixed to the registered g; pkt_v_o held, requester g must keep req_v_i and pkt stable. On pkt_ready_i: req_ready_o[g]=1, advance the pointer, go to IDLE. No re-arbitration while in HOLD. Credit checks are not re-evaluated in HOLD; the credit was reserved on entry.
- Zero-cycle path in IDLE: request-to-packet latency 0, one accepted packet per cycle max.
- Global credits: -1 on accepted send, +1 on credit_return_i, both in the same cycle -> unchanged. credit_return_i at max -> err_o, saturate.
- out_cnt[i]: +1 on accepted send with expect_rsp, -1 on response handoff to i; simultaneous -> unchanged; width clog2(max_req_out_p+1).
- Response demux: id = rsp_pkt_i[rsp_tag_lsb_p +: id_width_lp]. If id<num_req_p: rsp_v_o[id]=rsp_v_i, rsp_yumi_o=rsp_yumi_i[id], rsp_pkt_o=rsp_pkt_i. Response path is independent of the request FSM.
- Bad id (>=num_req_p) or response to out_cnt==0: rsp_yumi_o=1 (drop), rsp_v_o=0, err_o<=1 sticky until reset.
- busy_o = (credits!=max_out_credits_p) | any out_cnt!=0 | state==HOLD.

Decomposition:
- Package bsg_manycore_host_arb_pkg: state enum {e_idle, e_hold}; id stamp helper constants.
- Sub-module: reuse bsg_arb_round_robin for the grant. The credit/outstanding counter is a natural sub-module, bsg_manycore_host_arb_counter (up/down, saturating, underflow flag), instanced num_req_p+1 times.

Test Plan:
- All 3 requesters valid continuously, pkt_ready_i=1 -> grants 0,1,2,0,1,2; tag bits show 0,1,2; one packet per cycle.
- Requester 1 granted, pkt_ready_i low 4 cycles -> pkt_o stable, state HOLD, req 2 not granted; on ready, req_ready_o[1] pulses once, next grant 2.
- max_out_credits_p=2, no credit_return_i -> two sends then pkt_v_o=0; one credit_return_i -> exactly one more send; return+send same cycle -> credits unchanged.
- Requester 0 issues 16 expect_rsp requests -> requester 0 ineligible while others proceed; one response id=0 consumed -> requester 0 eligible next cycle.
- Response with id=3 (num_req_p=3) -> rsp_yumi_o=1, all rsp_v_o=0, err_o=1 stays set; reset clears it.
- reset_i asserted during HOLD -> next cycle pkt_v_o=0, credits=32, busy_o=0.
